// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the serial-multiplier sharing arbiter.
package mul_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam int DEF_WIDTH  = 9;
   localparam int DEF_NREQ   = 4;
   localparam int DEF_IDX_W  = $clog2(DEF_NREQ);
   localparam int DEF_PROD_W = 2 * DEF_WIDTH;

   // Index width, never below one bit so a grant index always exists.
   function automatic int idx_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically.
module rr_arbiter
   import mul_arb_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int IDX_W = DEF_IDX_W
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any_req
);

   always_comb begin
      int  j;
      logic found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      j         = 0;
      for (int i = 0; i < NREQ; i++) begin
         j = (int'(ptr) + i) % NREQ;
         if (!found && req[j]) begin
            found     = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = IDX_W'(j);
         end
      end
      any_req = |req;
   end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one signed serial multiplier among NREQ requesters with round-robin grants.
// Optional WAIT timeout is built only when MUL_ARB_TIMEOUT_EN is defined.
module mul_share_arbiter
   import mul_arb_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NREQ    = DEF_NREQ,
   parameter int TIMEOUT = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NREQ-1:0]               req,
   input  logic [NREQ*WIDTH-1:0]         req_a,
   input  logic [NREQ*WIDTH-1:0]         req_b,
   output logic [NREQ-1:0]               ack,
   output logic [2*WIDTH-1:0]            rsp_s,
   output logic                          rsp_err,
   output logic [idx_width(NREQ)-1:0]    grant_id,
   output logic                          busy,
   output logic                          mul_en,
   output logic [WIDTH-1:0]              mul_a,
   output logic [WIDTH-1:0]              mul_b,
   input  logic                          mul_valid,
   input  logic [2*WIDTH-1:0]            mul_s,
   output logic [1:0]                    dbg_state
);

   localparam int IDX_W  = idx_width(NREQ);
   localparam int PROD_W = 2 * WIDTH;
   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_ISSUE = ISSUE;
   localparam logic [1:0] S_WAIT  = WAIT;
   localparam logic [1:0] S_RESP  = RESP;

   if (NREQ < 2 || NREQ > 16 || TIMEOUT < 1) begin : g_bad_cfg
      $error("mul_share_arbiter: unsupported NREQ/TIMEOUT");
   end

   logic [1:0]        state_q, state_d;
   logic [IDX_W-1:0]  rr_q, rr_d;
   logic [IDX_W-1:0]  gid_q, gid_d;
   logic [NREQ-1:0]   goh_q, goh_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
   logic [PROD_W-1:0] s_q, s_d;
   logic              err_q, err_d;
   logic              valid_q;

   logic [NREQ-1:0]   arb_grant;
   logic [IDX_W-1:0]  arb_idx;
   logic              arb_any;
   logic              done;

   rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
      .req       (req),
      .ptr       (rr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any_req   (arb_any)
   );

   // Edge detect so a valid level left over from the last operation is ignored.
   assign done = mul_valid & ~valid_q;

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gid_d   = gid_q;
      goh_d   = goh_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      err_d   = err_q;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (arb_any) begin
               gid_d   = arb_idx;
               goh_d   = arb_grant;
               a_d     = req_a[arb_idx*WIDTH +: WIDTH];
               b_d     = req_b[arb_idx*WIDTH +: WIDTH];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
`ifdef MUL_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (done) begin
               s_d     = mul_s;
               err_d   = 1'b0;
               state_d = S_RESP;
            end
`ifdef MUL_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               s_d     = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
`endif
         end
         default: begin
            rr_d    = (gid_q == IDX_W'(NREQ - 1)) ? '0 : gid_q + IDX_W'(1);
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         gid_q   <= '0;
         goh_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gid_q   <= gid_d;
         goh_q   <= goh_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         err_q   <= err_d;
         valid_q <= mul_valid;
`ifdef MUL_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign ack       = (state_q == S_RESP) ? goh_q : '0;
   assign mul_en    = (state_q == S_ISSUE);
   assign busy      = (state_q != S_IDLE);
   assign rsp_s     = s_q;
   assign grant_id  = gid_q;
   assign mul_a     = a_q;
   assign mul_b     = b_q;
   assign dbg_state = state_q;
`ifdef MUL_ARB_TIMEOUT_EN
   assign rsp_err   = err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one signed serial multiplier (en/A/B in, valid/S out) between NREQ requesters.
- Round-robin arbitration, latches the winner's operands, pulses the multiplier start, waits for completion, and returns the product with a one-cycle ack.
- Sits between requester datapaths and a single signed_serial_multiplier instance.

Parameters:
WIDTH, 9, operand width in bits; product is 2*WIDTH bits
NREQ, 4, number of requesters (2..16)
TIMEOUT, 64, WAIT-state cycle limit; used only with MUL_ARB_TIMEOUT_EN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous, active-low reset
req  in  NREQ  per-requester request level
req_a  in  NREQ*WIDTH  signed operand A; requester i in slice [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  signed operand B, packed the same way
ack  out  NREQ  one-hot, one-cycle completion pulse
rsp_s  out  2*WIDTH  signed product, valid while ack is high and held until the next ack
rsp_err  out  1  timeout flag, qualified by ack
grant_id  out  $clog2(NREQ)  index of the requester currently being served
busy  out  1  high in any state other than IDLE
mul_en  out  1  one-cycle start pulse to the multiplier
mul_a, mul_b  out  WIDTH each  latched operands; stable from ISSUE until the next grant
mul_valid  in  1  multiplier done; may be a pulse or a level held from the previous operation
mul_s  in  2*WIDTH  multiplier product

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; rr pointer=0.
  - ack, mul_en, busy, rsp_err = 0; rsp_s, mul_a, mul_b, grant_id = 0; valid_q = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select the first requester at or after rr pointer, in cyclic order.
  - Latch its operands into mul_a/mul_b, set grant_id, go to ISSUE.
- ISSUE: mul_en=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - done = mul_valid & ~valid_q, where valid_q is mul_valid registered every cycle.
  - Rising-edge detection means a valid held high from the previous operation never completes a new one early.
  - On done: rsp_s <= mul_s, rsp_err <= 0, go to RESP.
- RESP:
  - ack[grant_id]=1 for one cycle.
  - rr pointer <= grant_id+1, wrapping at NREQ.
  - Go to IDLE.
- Latency: ack is issued 3 cycles + multiplier latency after req is sampled in IDLE. Throughput is at most one operation per (multiplier latency + 3) cycles.
- Requester rules:
  - Hold req and operands until ack, then drop req for at least one cycle or reissue a new operation.
  - If req drops while being served, the operation still completes and ack still pulses.
  - Operand changes after the IDLE latch are ignored.
- Simultaneous requests: rotating priority; a continuously requesting source waits at most NREQ-1 grants.
- Product is the full 2*WIDTH-bit signed result, passed through unmodified.
- Reset mid-operation: immediate return to IDLE, no ack issued, rr pointer=0. The multiplier shares rst_n.

Optional Feature:
- MUL_ARB_TIMEOUT_EN defined:
  - A WAIT cycle counter is cleared on entry to WAIT.
  - When the count reaches TIMEOUT without done: rsp_s <= 0, rsp_err <= 1, go to RESP (ack still pulses).
- Undefined: no counter is built, rsp_err is tied 0, and WAIT persists until done.

Decomposition:
- Package mul_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - localparams for index width ($clog2(NREQ)) and product width (2*WIDTH)
- Sub-module rr_arbiter (combinational): inputs req and pointer; outputs one-hot grant, grant index and any_req.

Test Plan:
- Single request: req[1]=1, A=-3, B=5 -> one ack[1] pulse, rsp_s=18'h3FFF1 (-15), rsp_err=0, mul_en pulsed exactly once.
- All four requesting from reset with distinct operands -> acks in order 0,1,2,3; each rsp_s equals the signed A*B for that requester.
- Fairness: req0 reissued immediately after each ack while req2 stays high -> grants alternate 0,2,0,2.
- Stale valid: mul_valid held high from the previous operation through ISSUE -> no ack until mul_valid falls and rises again.
- Reset in WAIT: rst_n=0 for one edge -> ack, busy and mul_en read 0 next cycle, no ack pulse; a following request (A=-256, B=-256) completes with rsp_s=65536.
- With MUL_ARB_TIMEOUT_EN and mul_valid stuck at 0 -> ack with rsp_err=1 and rsp_s=0 when the WAIT count reaches TIMEOUT (64); without the macro, busy stays high indefinitely.
